// File: rtl/rr_output_arbiter.sv
// Round-robin switch arbiter for one router output port.
// Locks the output to one input from header to tail flit.
module rr_output_arbiter #(
  parameter int N_IN   = 5,
  parameter int FLIT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          req,
  input  logic [N_IN-1:0]          empty,
  input  logic [3*N_IN-1:0]        flit_id_in,
  input  logic [FLIT_W*N_IN-1:0]   data_in,
  input  logic                     out_ready,
  output logic [N_IN-1:0]          rd_en,
  output logic                     valid_out,
  output logic [FLIT_W-1:0]        data_out,
  output logic [N_IN-1:0]          grant,
  output logic                     busy
);

  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] TAIL = 3'b100;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;

  logic [N_IN-1:0] elig;
  logic [N_IN-1:0] is_tail;
  logic [PW-1:0]   owner;
  logic [FLIT_W-1:0] own_data;
  logic            own_tail;
  logic            own_avail;
  logic            win_found;
  logic [N_IN-1:0] win_oh;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   nxt_ptr;
  logic            xfer;
  int              t;

  // Per-input eligibility and tail decode
  always_comb begin
    elig    = '0;
    is_tail = '0;
    for (int i = 0; i < N_IN; i++) begin
      elig[i]    = req[i] & ~empty[i] &
                   (flit_id_in[3*i +: 3] == HDR);
      is_tail[i] = (flit_id_in[3*i +: 3] == TAIL);
    end
  end

  // Owner index and owner head-flit view from the grant register
  always_comb begin
    owner    = '0;
    own_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) begin
        owner    = PW'(i);
        own_data = data_in[FLIT_W*i +: FLIT_W];
      end
    end
    own_tail  = |(grant & is_tail);
    own_avail = |(grant & ~empty);
  end

  // Rotating first-eligible search starting at ptr
  always_comb begin
    win_found = 1'b0;
    win_oh    = '0;
    idx       = '0;
    t         = 0;
    for (int k = 0; k < N_IN; k++) begin
      t = int'(ptr) + k;
      if (t >= N_IN) t = t - N_IN;
      idx = PW'(t);
      if (!win_found && elig[idx]) begin
        win_found   = 1'b1;
        win_oh[idx] = 1'b1;
      end
    end
  end

  assign nxt_ptr = (owner == PW'(N_IN - 1)) ? '0 : owner + PW'(1);

  assign xfer      = (state == BUSY) & own_avail & out_ready;
  assign rd_en     = grant & {N_IN{xfer}};
  assign valid_out = xfer;
  assign data_out  = xfer ? own_data : '0;
  assign busy      = (state == BUSY);

  // Arbitration and packet-lock state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant <= win_oh;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (xfer && own_tail) begin
            grant <= '0;
            state <= IDLE;
            ptr   <= nxt_ptr;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Bench for rr_output_arbiter: FIFO-queue model plus
// a packet-level arbitration model checked every cycle.
module tb_rr_output_arbiter;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] PAY  = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] d;
  } flit_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   req;
  logic [4:0]   empty;
  logic [14:0]  flit_id_in;
  logic [159:0] data_in;
  logic         out_ready;
  logic [4:0]   rd_en;
  logic         valid_out;
  logic [31:0]  data_out;
  logic [4:0]   grant;
  logic         busy;

  rr_output_arbiter #(.N_IN(5), .FLIT_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .empty(empty),
    .flit_id_in(flit_id_in), .data_in(data_in),
    .out_ready(out_ready), .rd_en(rd_en),
    .valid_out(valid_out), .data_out(data_out),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  flit_t q[5][$];
  logic [4:0] reqv;
  logic       ordy;
  int m_owner;
  int m_ptr;
  int wins[$];
  int rd_cnt[5];
  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      if (q[i].size() == 0) begin
        empty[i] = 1'b1;
        flit_id_in[3*i +: 3] = 3'b000;
        data_in[32*i +: 32] = 32'h0;
      end else begin
        empty[i] = 1'b0;
        flit_id_in[3*i +: 3] = q[i][0].id;
        data_in[32*i +: 32] = q[i][0].d;
      end
    end
    req = reqv;
    out_ready = ordy;
  endtask

  task automatic pkt(input int i, input int npay, input int tag);
    flit_t f;
    f.id = HDR;
    f.d = 32'((tag << 16) | (i << 8));
    q[i].push_back(f);
    for (int k = 1; k <= npay; k++) begin
      f.id = PAY;
      f.d = 32'((tag << 16) | (i << 8) | k);
      q[i].push_back(f);
    end
    f.id = TAIL;
    f.d = 32'((tag << 16) | (i << 8) | 8'hFF);
    q[i].push_back(f);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      q[i].delete();
      rd_cnt[i] = 0;
    end
    wins.delete();
    m_owner = -1;
    m_ptr = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model
  task automatic step();
    logic [4:0]  ge;
    logic [4:0]  re;
    logic [31:0] de;
    logic        x;
    int          w;
    logic [2:0]  hid;
    drive();
    @(negedge clk);
    ge = 5'b0;
    x = 1'b0;
    de = 32'h0;
    if (m_owner >= 0) begin
      ge = 5'(1 << m_owner);
      if (q[m_owner].size() > 0 && ordy) x = 1'b1;
    end
    re = x ? ge : 5'b0;
    if (x) de = q[m_owner][0].d;
    chk("grant", 32'(grant), 32'(ge));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("rd_en", 32'(rd_en), 32'(re));
    chk("valid_out", 32'(valid_out), 32'(x));
    chk("data_out", data_out, de);
    for (int i = 0; i < 5; i++) if (rd_en[i]) rd_cnt[i]++;
    if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < 5; k++) begin
        int c;
        c = (m_ptr + k) % 5;
        if (w < 0 && reqv[c] && q[c].size() > 0 && q[c][0].id == HDR)
          w = c;
      end
      if (w >= 0) begin
        m_owner = w;
        wins.push_back(w);
      end
    end else if (x) begin
      hid = q[m_owner][0].id;
      void'(q[m_owner].pop_front());
      if (hid == TAIL) begin
        m_ptr = (m_owner + 1) % 5;
        m_owner = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit pending();
    bit p;
    p = (m_owner >= 0);
    for (int i = 0; i < 5; i++) if (q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin
      step();
      n++;
    end
    total++;
    if (n >= max) begin
      bad++;
      $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, max);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    reqv = 5'b11111;
    ordy = 1'b1;
    model_reset();
    drive();
    @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rd_en", 32'(rd_en), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_data", data_out, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // idle with all FIFOs empty
    for (int n = 0; n < 10; n++) step();

    // header without request is never granted
    reqv = 5'b00000;
    pkt(0, 0, 1);
    for (int n = 0; n < 3; n++) step();
    chk("noreq_busy", 32'(busy), 32'h0);
    reqv = 5'b11111;
    drain(20);
    chk("noreq_win", 32'(wins[wins.size()-1]), 32'd0);

    // single packet on E
    do_reset();
    pkt(1, 1, 2);
    step();
    chk("single_grant", 32'(grant), 32'h02);
    drain(20);
    chk("single_rd_cnt", 32'(rd_cnt[1]), 32'd3);
    chk("single_ptr", 32'(m_ptr), 32'd2);
    step();
    chk("single_idle", 32'(busy), 32'h0);
    pkt(1, 0, 3);
    pkt(3, 0, 3);
    drain(30);
    chk("ptr2_win", 32'(wins[wins.size()-2]), 32'd3);
    chk("ptr2_next", 32'(wins[wins.size()-1]), 32'd1);

    // round-robin fairness, all inputs saturated
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pkt(i, 1, 4);
      pkt(i, 1, 5);
    end
    drain(100);
    chk("rr_count", 32'(wins.size()), 32'd10);
    for (int k = 0; k < 6; k++)
      chk("rr_order", 32'(wins[k]), 32'(k % 5));

    // backpressure with alternating out_ready
    do_reset();
    pkt(2, 2, 6);
    begin
      int n;
      n = 0;
      while (pending() && n < 40) begin
        ordy = (n % 2 == 1);
        step();
        n++;
      end
      chk("bp_drained", 32'(pending()), 32'h0);
    end
    ordy = 1'b1;
    chk("bp_rd_cnt", 32'(rd_cnt[2]), 32'd4);

    // owner FIFO runs dry mid-packet
    do_reset();
    begin
      flit_t f;
      f.id = HDR; f.d = 32'h3000_0300;
      q[3].push_back(f);
      f.id = PAY; f.d = 32'h3000_0301;
      q[3].push_back(f);
      for (int n = 0; n < 3; n++) step();
      for (int n = 0; n < 4; n++) step();
      chk("stall_grant", 32'(grant), 32'h08);
      chk("stall_busy", 32'(busy), 32'h1);
      f.id = PAY; f.d = 32'h3000_0302;
      q[3].push_back(f);
      f.id = TAIL; f.d = 32'h3000_03FF;
      q[3].push_back(f);
    end
    drain(20);
    chk("stall_rd_cnt", 32'(rd_cnt[3]), 32'd4);

    // N header blocked while L owns the output
    do_reset();
    pkt(4, 2, 7);
    step();
    step();
    pkt(0, 1, 8);
    drain(30);
    chk("lock_first", 32'(wins[0]), 32'd4);
    chk("lock_second", 32'(wins[1]), 32'd0);
    chk("lock_rd_cnt0", 32'(rd_cnt[0]), 32'd3);

    // asynchronous reset in the middle of a packet
    do_reset();
    pkt(2, 2, 9);
    step();
    step();
    chk("arst_pre_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_rd_en", 32'(rd_en), 32'h0);
    chk("arst_valid", 32'(valid_out), 32'h0);
    model_reset();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt(1, 0, 10);
    pkt(3, 0, 10);
    drain(30);
    chk("arst_rearb", 32'(wins[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_output_arbiter.md
# rr_output_arbiter

Per-output-port round-robin switch arbiter for the mesh router. One instance per output port (N, E, W, S, L). Each input port's LBDR produces a one-bit request toward this output; the arbiter picks one requesting input whose FIFO head is a header flit and locks the output to that input until its tail flit passes. While locked, it drives the input FIFO read enables and muxes the winner's flit onto the output.

## Interface
- N_IN, 5, number of requesting input ports; index 0..4 = N, E, W, S, L
- FLIT_W, 32, flit data width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N_IN  req[i]=1: input i's LBDR selected this output (held until the next header)
- empty  input  N_IN  empty[i]=1: input i's FIFO has no flit
- flit_id_in  input  3*N_IN  head-flit type per input, bits [3i+2:3i]; header 3'b001, payload 3'b010, tail 3'b100
- data_in  input  FLIT_W*N_IN  head-flit data per input, bits [FLIT_W*i +: FLIT_W]
- out_ready  input  1  downstream FIFO can accept a flit this cycle
- rd_en  output  N_IN  one-hot or zero; pops input i's FIFO this cycle
- valid_out  output  1  data_out carries a flit this cycle (write strobe downstream)
- data_out  output  FLIT_W  flit from the owning input; zero when valid_out=0
- grant  output  N_IN  registered one-hot owner; zero when idle
- busy  output  1  1 in BUSY state

## Operation
- State register: IDLE, BUSY. Registers: state, grant[N_IN], ptr (clog2(N_IN) bits, index of highest-priority input).
- Eligible input i: req[i] & ~empty[i] & (flit_id_in[i]==header).
- IDLE: if any input is eligible, search ptr, ptr+1, … wrapping mod N_IN; the first eligible input wins; grant<=onehot(winner), state<=BUSY. No flit moves in the arbitration cycle. If none is eligible, stay in IDLE.
- BUSY, owner o:
  - xfer = ~empty[o] & out_ready.
  - rd_en = grant & {N_IN{xfer}}.
  - valid_out = xfer.
  - data_out = data_in[o] when xfer.
- BUSY release: when xfer & flit_id_in[o]==tail, then grant<=0, state<=IDLE, ptr<=(o+1) mod N_IN (wraps 4→0).
- A header at the owner's FIFO head while BUSY is forwarded as an ordinary flit with no state change.
- An owner FIFO that is empty mid-packet stalls the output. The lock is held with no timeout.
- Requests and headers from non-owner inputs are ignored while BUSY. They keep no history and are re-evaluated in IDLE.
- Pointer updates only on release, so each input waits at most N_IN-1 packets.
- Outputs rd_en, valid_out and data_out are combinational from the grant register and the current inputs. No combinational path exists from req to any output.

## Timing
- Reset (async assert, sync-released by the top level): state=IDLE, grant=0, ptr=0, busy=0, rd_en=0, valid_out=0, data_out=0.
- Arbitration latency: an eligible header is visible in cycle t; grant and busy are set at edge t+1; the header transfers in cycle t+1 if out_ready=1.
- Throughput while BUSY: one flit per cycle when the owner is not empty and out_ready=1.
- Back-to-back packets:
  - Tail transfers in cycle t; state returns to IDLE at t+1.
  - Re-arbitration occurs in cycle t+1; the next header transfers in t+2.
  - This gives one bubble cycle per packet.
- Tail transferred with out_ready=0: no transfer and no release; the tail stays in the FIFO until out_ready=1.
- Reset mid-packet: grant clears immediately (async). The partial packet is abandoned, and the FIFOs are reset by the same rst.
- All N_IN inputs eligible simultaneously: exactly one grant, chosen by ptr.

## Test plan
- Reset then idle: rst pulse, all empty=1 → grant=0, busy=0, rd_en=0, valid_out=0 for 10 cycles.
- Single packet: input E (1) presents header/payload/tail with req[1]=1, out_ready=1 → grant=5'b00010 one cycle later; rd_en[1]=1 for 3 consecutive cycles; data_out matches; then busy=0 and ptr=2.
- Round-robin fairness: all 5 inputs continuously present 3-flit packets → grant order is N,E,W,S,L,N with each packet contiguous and one idle cycle between packets.
- Backpressure and starvation:
  - Toggle out_ready 1,0,1,0 → valid_out and rd_en only in out_ready=1 cycles.
  - Owner empty=1 for 4 cycles mid-packet → rd_en=0 and grant held.
- Contention lockout: input L owns the output mid-packet while input N presents a header with req[0]=1 → no rd_en[0] until L's tail transfers; N is granted on the following cycle (ptr wrapped 4→0).
- Async reset mid-packet: rst asserted between edges during BUSY → grant, busy and rd_en drop to 0 before the next edge; after release, a new header re-arbitrates from ptr=0.
